// File: rtl/fft_bitrev_stream.sv
// rtl/fft_bitrev_stream.sv - runtime-sized ping-pong bit-reversal reorder buffer with stream output
module fft_bitrev_stream #(
    parameter int WIDTH = 32,
    parameter int LGMAX = 8,
    parameter int LGMIN = 3,
    parameter int FCNTW = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ce,
    input  logic                         i_sync,
    input  logic [WIDTH-1:0]             i_sample,
    input  logic [$clog2(LGMAX+1)-1:0]   i_lgsize,
    input  logic                         i_clr,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_first,
    output logic                         o_last,
    output logic [FCNTW-1:0]             o_frame_cnt,
    output logic [1:0]                   o_status
);
    localparam int LW    = $clog2(LGMAX+1);
    localparam int DEPTH = 1 << LGMAX;

    typedef enum logic {WAIT_SYNC, FILL} wstate_t;

    function automatic logic [LGMAX-1:0] size_mask(input logic [LW-1:0] lg);
        size_mask = ~({LGMAX{1'b1}} << lg);
    endfunction

    // Reverse all LGMAX bits, then shift down so only the low lg bits carry the reversed index.
    function automatic logic [LGMAX-1:0] bit_reverse(input logic [LGMAX-1:0] v, input logic [LW-1:0] lg);
        logic [LGMAX-1:0] r;
        for (int b = 0; b < LGMAX; b++) r[b] = v[LGMAX-1-b];
        bit_reverse = r >> (LW'(LGMAX) - lg);
    endfunction

    logic [WIDTH-1:0] mem [0:2*DEPTH-1];

    wstate_t          wstate_q, wstate_d;
    logic [LGMAX-1:0] wk_q, wk_d;
    logic [LW-1:0]    wlg_q, wlg_d;
    logic             wbank_q, wbank_d;
    logic [LW-1:0]    lg_clamp;
    logic             mem_we, frame_done, set_ovf, set_short;
    logic [LGMAX-1:0] mem_waddr;

    // A bank stays full from its last write until its last address has been issued to the RAM.
    logic [1:0]       full_q;
    logic [LW-1:0]    bank_lg_q [2];
    logic             iss_bank_q;
    logic [LGMAX-1:0] iss_addr_q;
    logic             issue, iss_last, pop;
    logic [2:0]       credit;

    logic             rd_valid_q, rd_first_q, rd_last_q;
    logic [WIDTH-1:0] rd_data_q;

    logic [WIDTH-1:0] skid_data_q [2];
    logic [1:0]       skid_first_q, skid_last_q;
    logic             rp_q, wp_q;
    logic [1:0]       ocnt_q;
    logic [FCNTW-1:0] frame_cnt_q;
    logic [1:0]       status_q;

    // Clamp the requested frame size into the supported range.
    always_comb begin
        lg_clamp = i_lgsize;
        if (i_lgsize < LW'(LGMIN))      lg_clamp = LW'(LGMIN);
        else if (i_lgsize > LW'(LGMAX)) lg_clamp = LW'(LGMAX);
    end

    // Writer next-state: sync handling, bit-reversed write addressing, frame completion.
    always_comb begin
        wstate_d   = wstate_q;
        wk_d       = wk_q;
        wlg_d      = wlg_q;
        wbank_d    = wbank_q;
        mem_we     = 1'b0;
        frame_done = 1'b0;
        set_ovf    = 1'b0;
        set_short  = 1'b0;
        mem_waddr  = i_sync ? '0 : bit_reverse(wk_q, wlg_q);
        if (i_ce) begin
            if (i_sync) begin
                if (wstate_q == FILL) begin
                    set_short = 1'b1;
                    mem_we    = 1'b1;
                    wk_d      = LGMAX'(1);
                    wlg_d     = lg_clamp;
                end else if (!full_q[wbank_q]) begin
                    mem_we    = 1'b1;
                    wk_d      = LGMAX'(1);
                    wlg_d     = lg_clamp;
                    wstate_d  = FILL;
                end else begin
                    set_ovf   = 1'b1;
                end
            end else if (wstate_q == FILL) begin
                mem_we = 1'b1;
                if (wk_q == size_mask(wlg_q)) begin
                    frame_done = 1'b1;
                    wk_d       = '0;
                    wbank_d    = ~wbank_q;
                    wstate_d   = WAIT_SYNC;
                end else begin
                    wk_d = wk_q + 1'b1;
                end
            end
        end
    end

    // Writer state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wstate_q <= WAIT_SYNC;
            wk_q     <= '0;
            wlg_q    <= LW'(LGMIN);
            wbank_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wk_q     <= wk_d;
            wlg_q    <= wlg_d;
            wbank_q  <= wbank_d;
        end
    end

    // Issue a RAM read only if it is guaranteed a skid slot even if the consumer stalls.
    always_comb begin
        pop      = o_valid & i_ready;
        credit   = {1'b0, ocnt_q} + {2'b0, rd_valid_q} - {2'b0, pop};
        iss_last = (iss_addr_q == size_mask(bank_lg_q[iss_bank_q]));
        issue    = full_q[iss_bank_q] && (credit < 3'd2);
    end

    // Sample RAM: one write port from the writer, one registered read port for the reader.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[{wbank_q, mem_waddr}] <= i_sample;
        if (issue)  rd_data_q <= mem[{iss_bank_q, iss_addr_q}];
    end

    // Bank occupancy and natural-order read address sequencing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            full_q       <= '0;
            bank_lg_q[0] <= '0;
            bank_lg_q[1] <= '0;
            iss_bank_q   <= 1'b0;
            iss_addr_q   <= '0;
        end else begin
            if (frame_done) begin
                full_q[wbank_q]    <= 1'b1;
                bank_lg_q[wbank_q] <= wlg_q;
            end
            if (issue) begin
                if (iss_last) begin
                    full_q[iss_bank_q] <= 1'b0;
                    iss_bank_q         <= ~iss_bank_q;
                    iss_addr_q         <= '0;
                end else begin
                    iss_addr_q <= iss_addr_q + 1'b1;
                end
            end
        end
    end

    // Frame markers travel alongside the RAM read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= issue;
            if (issue) begin
                rd_first_q <= (iss_addr_q == '0);
                rd_last_q  <= iss_last;
            end
        end
    end

    // Two-entry output skid buffer; the head entry is what the consumer sees.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_first_q   <= '0;
            skid_last_q    <= '0;
            rp_q           <= 1'b0;
            wp_q           <= 1'b0;
            ocnt_q         <= '0;
        end else begin
            if (rd_valid_q) begin
                skid_data_q[wp_q]  <= rd_data_q;
                skid_first_q[wp_q] <= rd_first_q;
                skid_last_q[wp_q]  <= rd_last_q;
                wp_q               <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            ocnt_q <= ocnt_q + {1'b0, rd_valid_q} - {1'b0, pop};
        end
    end

    // Frame counter and sticky status; a same-cycle set beats a clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_cnt_q <= '0;
            status_q    <= '0;
        end else begin
            if (pop && o_last) frame_cnt_q <= frame_cnt_q + 1'b1;
            status_q <= (i_clr ? 2'b00 : status_q) | {set_short, set_ovf};
        end
    end

    assign o_valid     = (ocnt_q != 2'd0);
    assign o_data      = skid_data_q[rp_q];
    assign o_first     = o_valid & skid_first_q[rp_q];
    assign o_last      = o_valid & skid_last_q[rp_q];
    assign o_frame_cnt = frame_cnt_q;
    assign o_status    = status_q;
endmodule

// File: tb/tb_fft_bitrev_stream.sv
// tb/tb_fft_bitrev_stream.sv - self-checking bench for fft_bitrev_stream
module tb_fft_bitrev_stream;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ce = 1'b0;
    logic        i_sync = 1'b0;
    logic [31:0] i_sample = '0;
    logic [3:0]  i_lgsize = '0;
    logic        i_clr = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_valid, o_first, o_last;
    logic [31:0] o_data;
    logic [7:0]  o_frame_cnt;
    logic [1:0]  o_status;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ready_mode = 1;
    int          last_wcyc = 0;
    logic [33:0] obs_q[$];
    int          obs_cyc[$];
    logic [33:0] exp_q[$];
    logic [31:0] cur_fr[$];
    bit          stall_q = 1'b0;
    logic [33:0] stall_val = '0;

    fft_bitrev_stream #(.WIDTH(32), .LGMAX(8), .LGMIN(3), .FCNTW(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync),
        .i_sample(i_sample), .i_lgsize(i_lgsize), .i_clr(i_clr),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_first(o_first), .o_last(o_last), .o_frame_cnt(o_frame_cnt), .o_status(o_status)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Capture handshakes; a stalled output must hold its value until accepted.
    always @(negedge i_clk) begin
        if (i_reset) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                n_checks++;
                if (!(o_valid === 1'b1 && {o_data, o_first, o_last} === stall_val)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b word=%h want valid=1 word=%h", o_valid, {o_data, o_first, o_last}, stall_val);
                end
            end
            if (o_valid === 1'b1 && i_ready) begin
                obs_q.push_back({o_data, o_first, o_last});
                obs_cyc.push_back(cyc);
            end
            stall_q   <= (o_valid === 1'b1) && !i_ready;
            stall_val <= {o_data, o_first, o_last};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int clampl(input int l);
        return (l < 3) ? 3 : ((l > 8) ? 8 : l);
    endfunction

    function automatic int brev(input int v, input int l);
        int r = 0;
        for (int b = 0; b < l; b++) if (((v >> b) & 1) != 0) r |= 1 << (l - 1 - b);
        return r;
    endfunction

    task automatic do_reset();
        i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic send_frame(input int lgin, input int nsamp, input bit gaps, input bit ramp);
        cur_fr.delete();
        for (int k = 0; k < nsamp; k++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin
                i_ce = 1'b0; @(posedge i_clk); #1;
            end
            i_ce = 1'b1; i_sync = (k == 0); i_lgsize = 4'(lgin);
            i_sample = ramp ? 32'(k) : $urandom;
            cur_fr.push_back(i_sample);
            @(posedge i_clk); #1;
        end
        i_ce = 1'b0; i_sync = 1'b0; last_wcyc = cyc;
    endtask

    // Natural bin j of a frame is the sample that arrived at position bitrev(j).
    task automatic push_exp(input int lgin);
        int l = clampl(lgin);
        int n = 1 << l;
        for (int j = 0; j < n; j++) exp_q.push_back({cur_fr[brev(j, l)], 1'(j == 0), 1'(j == n - 1)});
    endtask

    task automatic wait_obs(input int n, input int budget);
        int c = 0;
        while (obs_q.size() < n && c < budget) begin @(posedge i_clk); #1; c++; end
        repeat (6) begin @(posedge i_clk); #1; end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_first !== 1'b0)   begin n_fail++; $display("FAIL reset_first: got %b want 0", o_first); end
        n_checks++; if (o_last !== 1'b0)    begin n_fail++; $display("FAIL reset_last: got %b want 0", o_last); end
        n_checks++; if (o_data !== 32'h0)   begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        n_checks++; if (o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_frame_cnt); end
        n_checks++; if (o_status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", o_status); end
    endtask

    task automatic test_ramp8();
        logic [31:0] want [8] = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
        ready_mode = 1;
        do_reset();
        send_frame(3, 8, 1'b0, 1'b1);
        wait_obs(8, 100);
        n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL ramp8_count: got %0d want 8", obs_q.size()); end
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== {want[i], 1'(i == 0), 1'(i == 7)}) begin
                n_fail++; $display("FAIL ramp8_out[%0d]: got %h want %h", i, obs_q[i], {want[i], 1'(i == 0), 1'(i == 7)});
            end
        end
        if (obs_cyc.size() > 0) begin
            n_checks++;
            if (obs_cyc[0] - last_wcyc != 2) begin n_fail++; $display("FAIL ramp8_latency: got %0d want 2", obs_cyc[0] - last_wcyc); end
        end
        n_checks++; if (o_frame_cnt !== 8'd1) begin n_fail++; $display("FAIL ramp8_cnt: got %0d want 1", o_frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        ready_mode = 1;
        do_reset();
        for (int f = 0; f < 10; f++) begin send_frame(6, 64, 1'b0, 1'b0); push_exp(6); end
        wait_obs(640, 2000);
        n_checks++; if (obs_q.size() != 640) begin n_fail++; $display("FAIL b2b_count: got %0d want 640", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) gaps++;
        n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
        n_checks++; if (o_frame_cnt !== 8'd10) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 10", o_frame_cnt); end
        n_checks++; if (o_status !== 2'b00) begin n_fail++; $display("FAIL b2b_status: got %b want 00", o_status); end
    endtask

    task automatic test_sizes();
        ready_mode = 1;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            send_frame((f % 2 == 1) ? 8 : 4, (f % 2 == 1) ? 256 : 16, 1'b0, 1'b0);
            push_exp((f % 2 == 1) ? 8 : 4);
            wait_obs(exp_q.size(), 1000);
        end
        n_checks++; if (obs_q.size() != 544) begin n_fail++; $display("FAIL sizes_count: got %0d want 544", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sizes_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (o_frame_cnt !== 8'd4) begin n_fail++; $display("FAIL sizes_cnt: got %0d want 4", o_frame_cnt); end
    endtask

    task automatic test_overflow();
        ready_mode = 0;
        do_reset();
        send_frame(5, 32, 1'b0, 1'b0); push_exp(5);
        send_frame(5, 32, 1'b0, 1'b0); push_exp(5);
        send_frame(5, 32, 1'b0, 1'b0);
        repeat (5) begin @(posedge i_clk); #1; end
        n_checks++; if (o_status !== 2'b01) begin n_fail++; $display("FAIL ovf_status: got %b want 01", o_status); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ovf_stalled_count: got %0d want 0", obs_q.size()); end
        ready_mode = 1;
        wait_obs(64, 500);
        n_checks++; if (obs_q.size() != 64) begin n_fail++; $display("FAIL ovf_count: got %0d want 64", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (o_frame_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 2", o_frame_cnt); end
        n_checks++; if (o_status !== 2'b01) begin n_fail++; $display("FAIL ovf_sticky: got %b want 01", o_status); end
        i_clr = 1'b1; @(posedge i_clk); #1; i_clr = 1'b0;
        n_checks++; if (o_status !== 2'b00) begin n_fail++; $display("FAIL ovf_clr: got %b want 00", o_status); end
    endtask

    task automatic test_short();
        ready_mode = 1;
        do_reset();
        send_frame(4, 5, 1'b0, 1'b0);
        send_frame(4, 16, 1'b0, 1'b0); push_exp(4);
        wait_obs(16, 200);
        n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL short_count: got %0d want 16", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL short_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (o_status !== 2'b10) begin n_fail++; $display("FAIL short_status: got %b want 10", o_status); end
        n_checks++; if (o_frame_cnt !== 8'd1) begin n_fail++; $display("FAIL short_cnt: got %0d want 1", o_frame_cnt); end
    endtask

    task automatic test_random_ready();
        int lgs [7] = '{0, 15, 5, 3, 7, 4, 6};
        ready_mode = 2;
        do_reset();
        for (int f = 0; f < 7; f++) begin
            send_frame(lgs[f], 1 << clampl(lgs[f]), 1'b1, 1'b0);
            push_exp(lgs[f]);
            wait_obs(exp_q.size(), 3000);
        end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (o_frame_cnt !== 8'd7) begin n_fail++; $display("FAIL rnd_cnt: got %0d want 7", o_frame_cnt); end
        n_checks++; if (o_status !== 2'b00) begin n_fail++; $display("FAIL rnd_status: got %b want 00", o_status); end
    endtask

    task automatic test_reset_mid();
        ready_mode = 1;
        do_reset();
        send_frame(3, 8, 1'b0, 1'b0);
        send_frame(6, 3, 1'b0, 1'b0);
        send_frame(6, 64, 1'b0, 1'b0);
        while (obs_q.size() < 18 && cyc < 90000) begin @(posedge i_clk); #1; end
        n_checks++; if (o_frame_cnt !== 8'd1) begin n_fail++; $display("FAIL rmid_pre_cnt: got %0d want 1", o_frame_cnt); end
        n_checks++; if (o_status !== 2'b10) begin n_fail++; $display("FAIL rmid_pre_status: got %b want 10", o_status); end
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", o_valid); end
        i_reset = 1'b1; @(posedge i_clk); #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", o_valid); end
        n_checks++; if (o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", o_frame_cnt); end
        n_checks++; if (o_status !== 2'b00) begin n_fail++; $display("FAIL rmid_status: got %b want 00", o_status); end
        n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", o_data); end
        i_reset = 1'b0;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        send_frame(3, 8, 1'b0, 1'b0); push_exp(3);
        wait_obs(8, 100);
        n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL rmid_count: got %0d want 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (o_frame_cnt !== 8'd1) begin n_fail++; $display("FAIL rmid_post_cnt: got %0d want 1", o_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_ramp8();
        test_back_to_back();
        test_sizes();
        test_overflow();
        test_short();
        test_random_ready();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
